// File: rtl/arinc429_tx_serializer.sv
// arinc429_tx_serializer
//
// Serializes one 32-bit ARINC 429 word onto a bipolar return-to-zero line
// pair. A single-cycle i_start pulse (from the upstream pulse synchronizer)
// latches the word and its options. The word is sent as 32 bits, each bit
// being one driven half-bit followed by one NULL half-bit. A NULL gap of
// GAP_BITS bit times follows the word, and then o_done pulses.
//
// Parameters:
//   HALF_BIT_HS - clocks per half-bit at high speed
//   HALF_BIT_LS - clocks per half-bit at low speed
//   GAP_BITS    - inter-word null gap, in bit times
//
// Ports:
//   i_clk       - clock
//   i_reset_n   - asynchronous, active-low reset
//   i_start     - one-cycle start pulse
//   i_word      - word to send, i_word[0] is ARINC bit 1
//   i_speed     - 0 = high speed, 1 = low speed (sampled with i_start)
//   i_parity_en - 1 = bit 32 replaced by odd parity (sampled with i_start)
//   o_tx_a      - HI leg, 1 = line at +V
//   o_tx_b      - LO leg, 1 = line at -V
//   o_busy      - word or gap in progress
//   o_done      - one-cycle pulse at the end of the gap
//   o_drop      - one-cycle pulse when i_start arrives while busy

module arinc429_tx_serializer #(
  parameter int HALF_BIT_HS = 250,
  parameter int HALF_BIT_LS = 2000,
  parameter int GAP_BITS    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_word,
  input  logic        i_speed,
  input  logic        i_parity_en,
  output logic        o_tx_a,
  output logic        o_tx_b,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_drop
);

  localparam int MAX_HALF   = (HALF_BIT_HS > HALF_BIT_LS) ? HALF_BIT_HS : HALF_BIT_LS;
  localparam int CNT_W      = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
  localparam int GAP_HALVES = 2 * GAP_BITS;
  localparam int GAP_W      = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

  localparam logic [CNT_W-1:0] HS_LOAD  = CNT_W'(HALF_BIT_HS - 1);
  localparam logic [CNT_W-1:0] LS_LOAD  = CNT_W'(HALF_BIT_LS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_HALVES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HALF1 = 2'd1;
  localparam logic [1:0] HALF2 = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       state;
  logic [31:0]      word_q;
  logic             speed_q;
  logic [4:0]       bit_idx;
  logic [CNT_W-1:0] half_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [31:0]      start_word;
  logic [CNT_W-1:0] start_load;
  logic [CNT_W-1:0] half_load;
  logic [4:0]       next_idx;
  logic             next_bit;

  // Transmission order: the label goes out MSB first (index 0 is word bit 7,
  // index 7 is word bit 0); indices 8..31 map straight onto word bits 8..31.
  function automatic logic tx_bit(input logic [31:0] w, input logic [4:0] idx);
    if (idx[4:3] == 2'b00)
      tx_bit = w[3'd7 - idx[2:0]];
    else
      tx_bit = w[idx];
  endfunction

  // Bit 32 is either passed through or replaced by odd parity over bits 1..31.
  always_comb begin
    start_word = {(i_parity_en ? ~^i_word[30:0] : i_word[31]), i_word[30:0]};
    start_load = i_speed ? LS_LOAD : HS_LOAD;
    half_load  = speed_q ? LS_LOAD : HS_LOAD;
    next_idx   = bit_idx + 5'd1;
    next_bit   = tx_bit(word_q, next_idx);
  end

  // Main sequencer. The line legs are loaded on the same edge that enters a
  // half so they are registered and change in lock-step with the state.
  // The gap is counted as GAP_HALVES passes of the half-bit counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      word_q   <= '0;
      speed_q  <= 1'b0;
      bit_idx  <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
      o_tx_a   <= 1'b0;
      o_tx_b   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_drop <= i_start & o_busy;
      case (state)
        IDLE: begin
          if (i_start) begin
            word_q   <= start_word;
            speed_q  <= i_speed;
            bit_idx  <= '0;
            half_cnt <= start_load;
            o_tx_a   <= i_word[7];
            o_tx_b   <= ~i_word[7];
            o_busy   <= 1'b1;
            state    <= HALF1;
          end
        end
        HALF1: begin
          if (half_cnt == '0) begin
            half_cnt <= half_load;
            o_tx_a   <= 1'b0;
            o_tx_b   <= 1'b0;
            state    <= HALF2;
          end else begin
            half_cnt <= half_cnt - CNT_ONE;
          end
        end
        HALF2: begin
          if (half_cnt == '0) begin
            half_cnt <= half_load;
            if (bit_idx == 5'd31) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              bit_idx <= next_idx;
              o_tx_a  <= next_bit;
              o_tx_b  <= ~next_bit;
              state   <= HALF1;
            end
          end else begin
            half_cnt <= half_cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (half_cnt == '0) begin
            if (gap_cnt == '0) begin
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= IDLE;
            end else begin
              gap_cnt  <= gap_cnt - GAP_ONE;
              half_cnt <= half_load;
            end
          end else begin
            half_cnt <= half_cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arinc429_tx_serializer.sv
// tb_arinc429_tx_serializer
//
// Scoreboard bench for arinc429_tx_serializer with small half-bit counts.
// Stimulus pushes hand-computed expectations (transmitted bit sequence,
// o_done cycle, busy length, o_drop cycle) into queues; a monitor on the
// falling clock edge pops and compares as the DUT produces them.

module tb_arinc429_tx_serializer;

  localparam int HS = 4;
  localparam int LS = 8;
  localparam int GB = 4;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_start;
  logic [31:0] i_word;
  logic        i_speed;
  logic        i_parity_en;
  logic        o_tx_a;
  logic        o_tx_b;
  logic        o_busy;
  logic        o_done;
  logic        o_drop;

  int total;
  int bad;
  int edge_cnt;

  int exp_bit_v[$];
  int exp_bit_h[$];
  int exp_done[$];
  int exp_busy_len[$];
  int exp_drop[$];

  arinc429_tx_serializer #(
    .HALF_BIT_HS(HS),
    .HALF_BIT_LS(LS),
    .GAP_BITS(GB)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_start(i_start),
    .i_word(i_word),
    .i_speed(i_speed),
    .i_parity_en(i_parity_en),
    .o_tx_a(o_tx_a),
    .o_tx_b(o_tx_b),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_drop(o_drop)
  );

  // Free-running clock and an edge counter used as the time base.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial edge_cnt = 0;
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  task automatic reportUnexpected(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got an event expected none (edge %0d)", name, edge_cnt);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Issues a start sampled at the next edge; seq holds the hand-computed
  // bit sequence in transmit order (seq[0] goes out first).
  task automatic applyStimulus(input logic [31:0] word, input logic spd,
                               input logic par, input logic [31:0] seq);
    int h;
    int s;
    h = spd ? LS : HS;
    s = edge_cnt;
    i_word      = word;
    i_speed     = spd;
    i_parity_en = par;
    i_start     = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_bit_v.push_back(int'(seq[i]));
      exp_bit_h.push_back(h);
    end
    exp_done.push_back(s + 64 * h + 2 * GB * h + 1);
    exp_busy_len.push_back(64 * h + 2 * GB * h);
    waitCycles(1);
    i_start = 1'b0;
  endtask

  // A start that arrives while busy: only an o_drop is expected.
  task automatic applyBusyStart(input logic [31:0] word);
    i_word      = word;
    i_speed     = 1'b1;
    i_parity_en = 1'b0;
    i_start     = 1'b1;
    exp_drop.push_back(edge_cnt + 1);
    waitCycles(1);
    i_start = 1'b0;
  endtask

  // Monitor: reconstructs each driven half-bit, checks leg exclusivity,
  // busy window length, and the o_done / o_drop timing.
  logic sym_active;
  int   sym_val;
  int   sym_len;
  logic busy_prev;
  int   busy_rise;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      sym_active = 1'b0;
      sym_len    = 0;
      busy_prev  = 1'b0;
    end else begin
      checkOutput("legs_exclusive", int'(o_tx_a & o_tx_b), 0);
      if (o_tx_a || o_tx_b) begin
        if (!sym_active) begin
          sym_active = 1'b1;
          sym_val    = int'(o_tx_a);
          sym_len    = 0;
        end
        sym_len++;
      end else if (sym_active) begin
        sym_active = 1'b0;
        if (exp_bit_v.size() == 0) begin
          reportUnexpected("bit_extra");
        end else begin
          checkOutput("bit_value", sym_val, exp_bit_v.pop_front());
          checkOutput("bit_len", sym_len, exp_bit_h.pop_front());
        end
      end
      if (o_busy && !busy_prev) busy_rise = edge_cnt;
      if (!o_busy && busy_prev) begin
        if (exp_busy_len.size() == 0) reportUnexpected("busy_fall");
        else checkOutput("busy_len", edge_cnt - busy_rise, exp_busy_len.pop_front());
      end
      busy_prev = o_busy;
      if (o_done) begin
        if (exp_done.size() == 0) reportUnexpected("done_extra");
        else begin
          checkOutput("done_cycle", edge_cnt, exp_done.pop_front());
          checkOutput("busy_at_done", int'(o_busy), 0);
        end
      end
      if (o_drop) begin
        if (exp_drop.size() == 0) reportUnexpected("drop_extra");
        else checkOutput("drop_cycle", edge_cnt, exp_drop.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total       = 0;
    bad         = 0;
    i_reset_n   = 1'b0;
    i_start     = 1'b0;
    i_word      = '0;
    i_speed     = 1'b0;
    i_parity_en = 1'b0;
    waitCycles(3);
    checkOutput("rst_tx_a", int'(o_tx_a), 0);
    checkOutput("rst_tx_b", int'(o_tx_b), 0);
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_done", int'(o_done), 0);
    checkOutput("rst_drop", int'(o_drop), 0);
    i_reset_n = 1'b1;
    waitCycles(2);

    $display("[TB] high-speed label with parity");
    applyStimulus(32'h0000_0081, 1'b0, 1'b1, 32'h8000_0081);
    checkOutput("busy_cycle1", int'(o_busy), 1);
    waitCycles(300);

    $display("[TB] parity disabled / enabled on bit 32");
    applyStimulus(32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000);
    waitCycles(300);
    applyStimulus(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    waitCycles(300);
    applyStimulus(32'h8000_0001, 1'b0, 1'b0, 32'h8000_0080);
    waitCycles(300);
    applyStimulus(32'h8000_0001, 1'b0, 1'b1, 32'h0000_0080);
    waitCycles(300);

    $display("[TB] low speed with inputs toggled mid-word");
    applyStimulus(32'h1234_5603, 1'b1, 1'b1, 32'h1234_56C0);
    waitCycles(100);
    i_speed     = 1'b0;
    i_parity_en = 1'b0;
    i_word      = 32'hFFFF_FFFF;
    waitCycles(500);

    $display("[TB] start while busy");
    applyStimulus(32'h0000_0081, 1'b0, 1'b1, 32'h8000_0081);
    waitCycles(49);
    applyBusyStart(32'h5555_AAAA);
    waitCycles(260);

    $display("[TB] reset mid-word");
    applyStimulus(32'h1234_5603, 1'b0, 1'b1, 32'h1234_56C0);
    waitCycles(99);
    i_reset_n = 1'b0;
    exp_bit_v.delete();
    exp_bit_h.delete();
    exp_done.delete();
    exp_busy_len.delete();
    exp_drop.delete();
    #1;
    checkOutput("midrst_tx_a", int'(o_tx_a), 0);
    checkOutput("midrst_tx_b", int'(o_tx_b), 0);
    checkOutput("midrst_busy", int'(o_busy), 0);
    checkOutput("midrst_done", int'(o_done), 0);
    checkOutput("midrst_drop", int'(o_drop), 0);
    waitCycles(2);
    i_reset_n = 1'b1;
    waitCycles(2);
    applyStimulus(32'h0000_0081, 1'b0, 1'b1, 32'h8000_0081);
    waitCycles(300);

    $display("[TB] back-to-back words");
    applyStimulus(32'h0000_0081, 1'b0, 1'b1, 32'h8000_0081);
    waitCycles(288);
    applyStimulus(32'h8000_0001, 1'b0, 1'b0, 32'h8000_0080);
    checkOutput("b2b_busy", int'(o_busy), 1);
    waitCycles(300);

    checkOutput("bits_left", exp_bit_v.size(), 0);
    checkOutput("done_left", exp_done.size(), 0);
    checkOutput("busy_left", exp_busy_len.size(), 0);
    checkOutput("drop_left", exp_drop.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arinc429_tx_serializer.md
# arinc429_tx_serializer

Serializes one 32-bit ARINC 429 word onto a bipolar return-to-zero line pair, started by a single-cycle pulse in the `i_clk` domain. In the ARINC 429 transmit path it sits directly downstream of the cross-domain one-shot pulse synchronizer; that synchronizer's output drives `i_start`. The block drives the line-driver control pins, enforces the inter-word gap, and reports completion.

## Interface
Parameters:
- HALF_BIT_HS, 250: clocks per half-bit at high speed (100 kbit/s at 50 MHz).
- HALF_BIT_LS, 2000: clocks per half-bit at low speed (12.5 kbit/s at 50 MHz).
- GAP_BITS, 4: inter-word null gap, in bit times.

Ports:
- i_clk, in, 1: clock.
- i_reset_n, in, 1: reset, asynchronous, active-low.
- i_start, in, 1: one-cycle start pulse from the pulse synchronizer.
- i_word, in, 32: word to send; i_word[0] is ARINC bit 1.
- i_speed, in, 1: 0 = high speed, 1 = low speed; sampled with i_start.
- i_parity_en, in, 1: 1 = replace bit 32 with odd parity; sampled with i_start.
- o_tx_a, out, 1: HI leg, 1 = line at +V.
- o_tx_b, out, 1: LO leg, 1 = line at −V.
- o_busy, out, 1: word or gap in progress.
- o_done, out, 1: one-cycle pulse at the end of the gap.
- o_drop, out, 1: one-cycle pulse when i_start arrives while busy.

## Operation
- Reset value of every output is 0; both legs at 0 means NULL.
- Asynchronous reset mid-word forces NULL and IDLE immediately. No o_done is issued.
- FSM states: IDLE, HALF1, HALF2, GAP.
- **IDLE**
  - On i_start with o_busy=0, the block latches the word, speed, and parity setting. It then loads bit index 0 and the half-bit counter, and moves to HALF1.
  - Latched word: bits 1–31 come from i_word[30:0].
  - Bit 32 = ~^i_word[30:0] if i_parity_en, else i_word[31].
- **Transmit order**
  - Label first, MSB first: i_word[7], i_word[6] … i_word[0].
  - Then i_word[8] … bit 32, ascending.
  - Bit index 0–31 maps to the position above.
- **HALF1**: drive the current bit for H clocks. 1 → o_tx_a=1, o_tx_b=0; 0 → o_tx_a=0, o_tx_b=1.
- **HALF2**: NULL for H clocks. Then either increment the index and return to HALF1, or, after index 31, go to GAP.
- **GAP**: NULL for 2·GAP_BITS·H clocks, then return to IDLE and pulse o_done.
- H = HALF_BIT_LS if latched speed = 1, else HALF_BIT_HS.
- Half-bit counter width = $clog2 of the larger of HALF_BIT_HS and HALF_BIT_LS. It counts H−1 down to 0.
- The gap counter reuses the half-bit counter plus a half-bit count of 2·GAP_BITS.
- o_tx_a and o_tx_b are registered and are never 1 simultaneously.
- i_start while o_busy=1: one-cycle o_drop in the following cycle. Transmission is unaffected and the latched word, speed, and parity are unchanged.
- i_speed, i_parity_en, and i_word changes outside a start cycle have no effect.

## Timing
- i_start sampled at edge 0 → o_busy=1 and bit 1 of the sequence (i_word[7]) on the line from cycle 1.
- Word duration is 64·H cycles; the gap is 2·GAP_BITS·H cycles.
- o_busy stays high for cycles 1 … 64·H + 2·GAP_BITS·H.
- The cycle after the last gap cycle: o_done=1 and o_busy=0.
- An i_start in that same cycle is accepted: back-to-back words with no extra idle.
- o_drop latency: 1 cycle after the offending i_start.

## Test plan
Simulation overrides: HALF_BIT_HS=4, HALF_BIT_LS=8, GAP_BITS=4.
1. **High-speed label with parity.** i_word=32'h0000_0081, i_parity_en=1, i_speed=0, start at cycle 0.
   - Cycles 1–4: a=1. Cycles 5–8: NULL. Then 0 for six bits, then 1 (i_word[0]), then bits 9–31 all 0, then bit 32=1.
   - o_done at cycle 289; o_busy high for cycles 1–288.
2. **Parity disabled.** i_word=32'h8000_0000, i_parity_en=0 → bit 32 sent as 1 (a=1 in half 63). With i_word=32'h0 → bit 32 is 0 (b=1).
3. **Low speed.** i_speed=1, any word → each half lasts 8 cycles, o_done at cycle 577. Toggling i_speed mid-word changes nothing.
4. **Start while busy.** Start at cycle 0, second i_start at cycle 50 with a different word → o_drop=1 at cycle 51 only. Line output is identical to the single-start case.
5. **Reset mid-word.** Assert i_reset_n=0 at cycle 100 → a, b, busy, done, and drop all 0 immediately, with no o_done. After release, a new start transmits normally from cycle 1.
6. **Back-to-back.** i_start asserted in the o_done cycle (289) → next word's first half starts at cycle 290, and o_busy drops for exactly that one cycle.
